pat_det_mod: RTL and testbench

- Serial pattern detector and deserializer. It sits directly downstream of shft_mod and consumes its serial cout stream.
- It assembles incoming bits into WIDTH-bit words and flags every position where the last WIDTH bits equal a programmable pattern. Overlapping matches count.
- It keeps a saturating match counter for software/debug readback.

---
 rtl/pat_det_mod.sv | 81 ++++++++
 tb/tb_pat_det_mod.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pat_det_mod.sv
// pat_det_mod: serial pattern detector and deserializer with saturating match counter.
// Define PAT_MASK_EN to add pat_mask_in, a per-bit compare mask (0 = don't care).
module pat_det_mod #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             dir,
  input  logic             pat_ld,
  input  logic [WIDTH-1:0] pat_in,
`ifdef PAT_MASK_EN
  input  logic [WIDTH-1:0] pat_mask_in,
`endif
  input  logic             clr_cnt,
  output logic             armed,
  output logic             match,
  output logic             word_vld,
  output logic [WIDTH-1:0] word_out,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [FW-1:0] LAST = FW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] hist, hist_nxt, pattern, mask;
  logic [FW-1:0] fill, fill_nxt, bitcnt, bitcnt_nxt;
  logic dir_q, restart, accept, match_nxt, word_nxt;
  // A direction flip starts a new stream: the accepted bit becomes the first of it.
  always_comb begin
    accept = bit_vld && !pat_ld;
    restart = dir != dir_q;
    hist_nxt = dir ? {bit_in, hist[WIDTH-1:1]} : {hist[WIDTH-2:0], bit_in};
    fill_nxt = restart ? FW'(1) : (fill == FULL ? FULL : fill + FW'(1));
    bitcnt_nxt = restart ? FW'(1) : (bitcnt == LAST ? '0 : bitcnt + FW'(1));
    match_nxt = accept && state != IDLE && fill_nxt == FULL && ((hist_nxt ^ pattern) & mask) == '0;
    word_nxt = accept && bitcnt_nxt == '0;
    state_nxt = pat_ld ? FILL : (accept && state != IDLE) ? (fill_nxt == FULL ? HUNT : FILL) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hist <= '0;
      pattern <= '0;
      fill <= '0;
      bitcnt <= '0;
      dir_q <= 1'b0;
      match <= 1'b0;
      word_vld <= 1'b0;
      word_out <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_nxt;
      match <= match_nxt;
      word_vld <= word_nxt;
      match_cnt <= clr_cnt ? '0 : (match && match_cnt != '1) ? match_cnt + CNT_W'(1) : match_cnt;
      if (pat_ld) begin
        pattern <= pat_in;
        fill <= '0;
      end else if (bit_vld) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
        bitcnt <= bitcnt_nxt;
        dir_q <= dir;
      end
      if (word_nxt) word_out <= hist_nxt;
    end
  end
`ifdef PAT_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) mask <= '1;
    else if (pat_ld) mask <= pat_mask_in;
  end
`else
  assign mask = '1;
`endif
  assign armed = state == HUNT;
endmodule

// File: tb/tb_pat_det_mod.sv
// tb_pat_det_mod: directed and random checks of pat_det_mod (CNT_W=8 and CNT_W=2 instances).
module tb_pat_det_mod;
  logic clk = 0, rst = 1, bit_vld = 0, bit_in = 0, dir = 0, pat_ld = 0, clr_cnt = 0;
  logic [7:0] pat_in = 0;
  logic armed, match, word_vld, armed2, match2, word_vld2;
  logic [7:0] word_out, match_cnt, word_out2;
  logic [1:0] match_cnt2;
  int errs = 0, checks = 0;
  int m_hist, m_pat, m_fill, m_bc, m_word, m_cnt, m_cnt2;
  bit m_dq, m_ld, m_match, m_wv;

  pat_det_mod #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .bit_vld(bit_vld), .bit_in(bit_in), .dir(dir), .pat_ld(pat_ld),
    .pat_in(pat_in),
`ifdef PAT_MASK_EN
    .pat_mask_in(8'hFF),
`endif
    .clr_cnt(clr_cnt), .armed(armed), .match(match), .word_vld(word_vld),
    .word_out(word_out), .match_cnt(match_cnt));

  pat_det_mod #(.WIDTH(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .bit_vld(bit_vld), .bit_in(bit_in), .dir(dir), .pat_ld(pat_ld),
    .pat_in(pat_in),
`ifdef PAT_MASK_EN
    .pat_mask_in(8'hFF),
`endif
    .clr_cnt(clr_cnt), .armed(armed2), .match(match2), .word_vld(word_vld2),
    .word_out(word_out2), .match_cnt(match_cnt2));

  always #5 clk = ~clk;

  function automatic logic [31:0] mvec();
    return {m_match, m_wv, m_ld && m_fill == 8, 8'(m_word), 8'(m_cnt), 2'(m_cnt2),
            m_match, m_wv, m_ld && m_fill == 8};
  endfunction

  function automatic logic [31:0] ovec();
    return {match, word_vld, armed, word_out, match_cnt, match_cnt2, match2, word_vld2, armed2};
  endfunction

  // Drive one clock of stimulus, then advance the reference model by that clock.
  task automatic cyc(input bit v, input bit b, input bit d, input bit l, input logic [7:0] p,
                     input bit c, input bit r);
    rst = r; bit_vld = v; bit_in = b; dir = d; pat_ld = l; pat_in = p; clr_cnt = c;
    @(posedge clk);
    #1;
    if (r) begin
      m_hist = 0; m_pat = 0; m_fill = 0; m_bc = 0; m_word = 0; m_cnt = 0; m_cnt2 = 0;
      m_dq = 0; m_ld = 0; m_match = 0; m_wv = 0;
    end else begin
      m_cnt = c ? 0 : (m_match && m_cnt < 255) ? m_cnt + 1 : m_cnt;
      m_cnt2 = c ? 0 : (m_match && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
      m_match = 0;
      m_wv = 0;
      if (l) begin
        m_pat = p; m_fill = 0; m_ld = 1;
      end else if (v) begin
        m_hist = d ? (m_hist / 2) + b * 128 : (m_hist * 2 + b) % 256;
        if (d != m_dq) begin
          m_fill = 1; m_bc = 1;
        end else begin
          m_fill = m_fill < 8 ? m_fill + 1 : 8; m_bc = (m_bc + 1) % 8;
        end
        m_dq = d;
        if (m_bc == 0) begin m_word = m_hist; m_wv = 1; end
        m_match = m_ld && m_fill == 8 && m_hist == m_pat;
      end
    end
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    rst = 0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 8'h5A, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (ovec() !== 32'h0) begin errs++; $display("FAIL reset: got %h expected %h", ovec(), 32'h0); end
  endtask

  task automatic test_msb_first();
    logic [7:0] w = 8'h56;
    do_reset();
    cyc(0, 0, 0, 1, w, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      cyc(1, w[i], 0, 0, 0, 0, 0);
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL msb_bit%0d: got %h expected %h", 7 - i, ovec(), mvec()); end
    end
    checks++;
    if ({armed, match, word_vld, word_out} !== {3'b111, 8'h56}) begin
      errs++; $display("FAIL msb_match: got %b %b %b %h expected 1 1 1 56", armed, match, word_vld, word_out);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({match, match_cnt} !== {1'b0, 8'd1}) begin errs++; $display("FAIL msb_cnt: got %b %0d expected 0 1", match, match_cnt); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'hA9;
    do_reset();
    cyc(0, 0, 1, 1, w, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, w[i], 1, 0, 0, 0, 0);
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL lsb_bit%0d: got %h expected %h", i, ovec(), mvec()); end
    end
    checks++;
    if ({match, word_vld, word_out} !== {2'b11, 8'hA9}) begin
      errs++; $display("FAIL lsb_match: got %b %b %h expected 1 1 a9", match, word_vld, word_out);
    end
  endtask

  task automatic test_gaps();
    int nm = 0, nw = 0;
    do_reset();
    cyc(0, 0, 0, 1, 8'hAA, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, (i % 2 == 0), 0, 0, 0, 0, 0);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ovec() !== mvec()) begin errs++; $display("FAIL gaps_bit%0d_%0d: got %h expected %h", i, g, ovec(), mvec()); end
        nm += match; nw += word_vld;
        if (g < 2) cyc(0, 0, 0, 0, 0, 0, 0);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (nm != 2 || nw != 1 || match_cnt !== 8'd2) begin
      errs++; $display("FAIL gaps_count: got match=%0d word=%0d cnt=%0d expected 2 1 2", nm, nw, match_cnt);
    end
  endtask

  task automatic test_reload();
    logic [7:0] w = 8'h56;
    int early = 0;
    do_reset();
    cyc(0, 0, 0, 1, w, 0, 0);
    for (int i = 7; i >= 3; i--) cyc(1, w[i], 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, w, 0, 0);
    checks++;
    if (ovec() !== mvec()) begin errs++; $display("FAIL reload_ld: got %h expected %h", ovec(), mvec()); end
    for (int i = 7; i >= 0; i--) begin
      cyc(1, w[i], 0, 0, 0, 0, 0);
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL reload_bit%0d: got %h expected %h", 7 - i, ovec(), mvec()); end
      if (i > 0) early += match;
    end
    checks++;
    if (early != 0 || match !== 1'b1) begin errs++; $display("FAIL reload_match: got early=%0d match=%b expected 0 1", early, match); end
  endtask

  task automatic test_saturate();
    int nm = 0;
    do_reset();
    cyc(0, 0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      nm += match;
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL sat_bit%0d: got %h expected %h", i, ovec(), mvec()); end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (nm != 5 || match_cnt !== 8'd5 || match_cnt2 !== 2'd3) begin
      errs++; $display("FAIL sat_count: got n=%0d cnt=%0d cnt2=%0d expected 5 5 3", nm, match_cnt, match_cnt2);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (match !== 1'b1) begin errs++; $display("FAIL sat_pulse: got %b expected 1", match); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({match_cnt, match_cnt2} !== 10'd0) begin errs++; $display("FAIL sat_clr: got %0d %0d expected 0 0", match_cnt, match_cnt2); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'h56;
    int nm = 0;
    do_reset();
    cyc(0, 0, 0, 1, w, 0, 0);
    for (int i = 7; i >= 4; i--) cyc(1, w[i], 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (ovec() !== 32'h0) begin errs++; $display("FAIL rstmid_zero: got %h expected %h", ovec(), 32'h0); end
    for (int i = 7; i >= 0; i--) begin
      cyc(1, w[i], 0, 0, 0, 0, 0);
      nm += match;
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL rstmid_idle%0d: got %h expected %h", 7 - i, ovec(), mvec()); end
    end
    checks++;
    if (nm != 0 || word_vld !== 1'b1 || word_out !== 8'h56) begin
      errs++; $display("FAIL rstmid_idle: got n=%0d wv=%b word=%h expected 0 1 56", nm, word_vld, word_out);
    end
    cyc(0, 0, 0, 1, w, 0, 0);
    for (int i = 7; i >= 0; i--) cyc(1, w[i], 0, 0, 0, 0, 0);
    checks++;
    if (match !== 1'b1) begin errs++; $display("FAIL rstmid_match: got %b expected 1", match); end
  endtask

  task automatic test_random();
    bit d = 0;
    logic [7:0] p;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(49) == 0) d = ~d;
      case ($urandom_range(2))
        0: p = 8'h00;
        1: p = 8'(m_hist);
        default: p = 8'($urandom);
      endcase
      cyc($urandom_range(3) != 0, $urandom_range(4) == 0, d, $urandom_range(59) == 0, p,
          $urandom_range(39) == 0, $urandom_range(399) == 0);
      checks++;
      if (ovec() !== mvec()) begin errs++; $display("FAIL random_%0d: got %h expected %h", n, ovec(), mvec()); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_reload();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
